// File: rtl/om_sync.sv
// om_sync: clocked SDM-Clos output module. Wormhole switch from MN CM links to NN output ports, each with a 2-entry FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   di_i/di_eof_i   : per-input flit data ([i*DW +: DW]) and end-of-packet flag
//   di_dec_i        : per-input one-hot output select ([i*NN +: NN])
//   di_vld_i/di_rdy_o : per-input handshake
//   do_o/do_eof_o   : per-output FIFO head data ([j*DW +: DW]) and end-of-packet flag
//   do_vld_o/do_rdy_i : per-output handshake
module om_sync #(
    parameter int MN = 2,
    parameter int NN = 2,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MN*DW-1:0] di_i,
    input  logic [MN-1:0]    di_eof_i,
    input  logic [MN*NN-1:0] di_dec_i,
    input  logic [MN-1:0]    di_vld_i,
    output logic [MN-1:0]    di_rdy_o,
    output logic [NN*DW-1:0] do_o,
    output logic [NN-1:0]    do_eof_o,
    output logic [NN-1:0]    do_vld_o,
    input  logic [NN-1:0]    do_rdy_i
);
    localparam int IW = (MN > 1) ? $clog2(MN) : 1;
    typedef enum logic {IDLE, LOCKED} state_e;
    logic [NN-1:0][MN-1:0] req;
    logic [MN-1:0][NN-1:0] acc;
    logic [MN-1:0]         oh;
    for (genvar i = 0; i < MN; i++) begin : g_in
        logic [NN-1:0] dec;
        assign dec = di_dec_i[i*NN +: NN];
        // zero or multi-hot directions request nothing, so such a flit stalls
        assign oh[i] = (dec != '0) && ((dec & (dec - NN'(1))) == '0);
        for (genvar j = 0; j < NN; j++) begin : g_req
            assign req[j][i] = di_vld_i[i] & oh[i] & dec[j];
        end
        assign di_rdy_o[i] = ~rst & (|acc[i]);
    end
    for (genvar j = 0; j < NN; j++) begin : g_out
        state_e        state_q, state_d;
        logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, sel, idx;
        logic [IW:0]   tt;
        logic [DW:0]   mem_q [2];
        logic          wr_q, rd_q;
        logic [1:0]    cnt_q, cnt_d;
        logic [MN-1:0] gnt;
        logic          any, full, push, pop, eof_in;
        logic [DW-1:0] dat_in;
        always_comb begin
            any = 1'b0;
            sel = ptr_q;
            tt = '0;
            idx = '0;
            // round-robin scan starting at ptr, wrapping modulo MN
            for (int k = 0; k < MN; k++) begin
                tt = {1'b0, ptr_q} + (IW+1)'(k);
                if (tt >= (IW+1)'(MN))
                    tt = tt - (IW+1)'(MN);
                idx = tt[IW-1:0];
                if (!any && req[j][idx]) begin
                    any = 1'b1;
                    sel = idx;
                end
            end
            if (state_q == LOCKED) begin
                sel = owner_q;
                any = req[j][owner_q];
            end
            gnt = '0;
            gnt[sel] = any;
            full = (cnt_q == 2'd2);
            push = any & ~full;
            pop = (cnt_q != 2'd0) & do_rdy_i[j];
            eof_in = di_eof_i[sel];
            dat_in = di_i[sel*DW +: DW];
            cnt_d = cnt_q + 2'(push) - 2'(pop);
            state_d = state_q;
            owner_d = owner_q;
            ptr_d = ptr_q;
            if (push) begin
                state_d = eof_in ? IDLE : LOCKED;
                owner_d = sel;
                if (state_q == IDLE)
                    ptr_d = (sel == IW'(MN-1)) ? '0 : sel + IW'(1);
            end
        end
        for (genvar i = 0; i < MN; i++) begin : g_acc
            assign acc[i][j] = gnt[i] & ~full;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q <= '0;
                cnt_q <= '0;
                wr_q <= 1'b0;
                rd_q <= 1'b0;
                mem_q[0] <= '0;
                mem_q[1] <= '0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q <= ptr_d;
                cnt_q <= cnt_d;
                if (push) begin
                    mem_q[wr_q] <= {eof_in, dat_in};
                    wr_q <= ~wr_q;
                end
                if (pop)
                    rd_q <= ~rd_q;
            end
        end
        assign do_o[j*DW +: DW] = mem_q[rd_q][DW-1:0];
        assign do_eof_o[j] = mem_q[rd_q][DW];
        assign do_vld_o[j] = ~rst & (cnt_q != 2'd0);
    end
endmodule

// File: tb/tb_om_sync.sv
// tb_om_sync: directed self-checking bench for om_sync (MN=2, NN=2, DW=8).
module tb_om_sync;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] di;
    logic [1:0]  di_eof, di_vld, di_rdy;
    logic [3:0]  di_dec;
    logic [15:0] dout;
    logic [1:0]  do_eof, do_vld, do_rdy;
    int checks = 0;
    int failures = 0;

    om_sync #(.MN(2), .NN(2), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .di_i(di), .di_eof_i(di_eof), .di_dec_i(di_dec), .di_vld_i(di_vld), .di_rdy_o(di_rdy),
        .do_o(dout), .do_eof_o(do_eof), .do_vld_o(do_vld), .do_rdy_i(do_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int i, input logic [7:0] d, input logic e, input logic [1:0] dec, input logic v);
        di[i*8 +: 8] = d;
        di_eof[i] = e;
        di_dec[i*2 +: 2] = dec;
        di_vld[i] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        do_rdy = 2'b11;
        drive(0, 8'h11, 1'b1, 2'b01, 1'b1);
        drive(1, 8'h22, 1'b1, 2'b01, 1'b1);
        tick();
        tick();
        checks++; if (di_rdy !== 2'b00) begin failures++; $display("FAIL reset_rdy got=%b exp=00", di_rdy); end
        checks++; if (do_vld !== 2'b00) begin failures++; $display("FAIL reset_vld got=%b exp=00", do_vld); end
        checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_do got=%h exp=0000", dout); end
        rst = 1'b0;
        #1;
        checks++; if (di_rdy !== 2'b01) begin failures++; $display("FAIL reset_first_grant got=%b exp=01", di_rdy); end
        tick();
        drive(0, 8'h11, 1'b1, 2'b01, 1'b0);
        #1;
        checks++; if (di_rdy !== 2'b10) begin failures++; $display("FAIL reset_second_grant got=%b exp=10", di_rdy); end
        checks++; if (do_vld !== 2'b01 || dout[7:0] !== 8'h11) begin failures++; $display("FAIL reset_out1 got=%b/%h exp=01/11", do_vld, dout[7:0]); end
        tick();
        drive(1, 8'h22, 1'b1, 2'b01, 1'b0);
        #1;
        checks++; if (do_vld !== 2'b01 || dout[7:0] !== 8'h22) begin failures++; $display("FAIL reset_out2 got=%b/%h exp=01/22", do_vld, dout[7:0]); end
        tick();
        checks++; if (do_vld !== 2'b00) begin failures++; $display("FAIL reset_drain got=%b exp=00", do_vld); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
        logic       exp_v [7]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_do [7]  = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
        logic       exp_e [7]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int na = 0;
        int nb = 0;
        do_rdy = 2'b11;
        for (int c = 0; c < 7; c++) begin
            drive(0, 8'(8'hA0 + na), na == 2, 2'b10, na < 3);
            drive(1, 8'(8'hB0 + nb), nb == 2, 2'b10, nb < 3);
            #1;
            checks++; if (di_rdy !== exp_rdy[c]) begin failures++; $display("FAIL cont_rdy c=%0d got=%b exp=%b", c, di_rdy, exp_rdy[c]); end
            checks++; if (do_vld[1] !== exp_v[c]) begin failures++; $display("FAIL cont_vld c=%0d got=%b exp=%b", c, do_vld[1], exp_v[c]); end
            if (c > 0) begin
                checks++; if (dout[15:8] !== exp_do[c] || do_eof[1] !== exp_e[c]) begin failures++; $display("FAIL cont_do c=%0d got=%h/%b exp=%h/%b", c, dout[15:8], do_eof[1], exp_do[c], exp_e[c]); end
            end
            if (di_rdy[0]) na++;
            if (di_rdy[1]) nb++;
            tick();
        end
        checks++; if (do_vld !== 2'b00) begin failures++; $display("FAIL cont_drain got=%b exp=00", do_vld); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [7:0] exp_do [5]  = '{8'h00, 8'h10, 8'h20, 8'h11, 8'h21};
        int n0 = 0;
        int n1 = 0;
        do_rdy = 2'b11;
        for (int c = 0; c < 5; c++) begin
            drive(0, 8'(8'h10 + n0), 1'b1, 2'b01, n0 < 2);
            drive(1, 8'(8'h20 + n1), 1'b1, 2'b01, n1 < 2);
            #1;
            checks++; if (di_rdy !== exp_rdy[c]) begin failures++; $display("FAIL rr_rdy c=%0d got=%b exp=%b", c, di_rdy, exp_rdy[c]); end
            if (c > 0) begin
                checks++; if (do_vld[0] !== 1'b1 || dout[7:0] !== exp_do[c]) begin failures++; $display("FAIL rr_do c=%0d got=%b/%h exp=1/%h", c, do_vld[0], dout[7:0], exp_do[c]); end
            end
            if (di_rdy[0]) n0++;
            if (di_rdy[1]) n1++;
            tick();
        end
        checks++; if (do_vld !== 2'b00) begin failures++; $display("FAIL rr_drain got=%b exp=00", do_vld); end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_rdy [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic       exp_v [9]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_do [9]  = '{8'h00, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00};
        int n = 0;
        do_rdy = 2'b10;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) begin
                checks++; if (n !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", n); end
                do_rdy = 2'b11;
            end
            drive(0, 8'(8'hC0 + n), n == 3, 2'b01, n < 4);
            #1;
            checks++; if (di_rdy !== exp_rdy[c]) begin failures++; $display("FAIL bp_rdy c=%0d got=%b exp=%b", c, di_rdy, exp_rdy[c]); end
            checks++; if (do_vld[0] !== exp_v[c]) begin failures++; $display("FAIL bp_vld c=%0d got=%b exp=%b", c, do_vld[0], exp_v[c]); end
            if (exp_v[c]) begin
                checks++; if (dout[7:0] !== exp_do[c]) begin failures++; $display("FAIL bp_do c=%0d got=%h exp=%h", c, dout[7:0], exp_do[c]); end
            end
            if (c == 7) begin
                checks++; if (do_eof[0] !== 1'b1) begin failures++; $display("FAIL bp_eof got=%b exp=1", do_eof[0]); end
            end
            if (di_rdy[0]) n++;
            tick();
        end
    endtask

    task automatic test_parallel_illegal();
        do_rdy = 2'b11;
        drive(0, 8'h31, 1'b1, 2'b01, 1'b1);
        drive(1, 8'h42, 1'b1, 2'b10, 1'b1);
        #1;
        checks++; if (di_rdy !== 2'b11) begin failures++; $display("FAIL par_rdy got=%b exp=11", di_rdy); end
        tick();
        drive(0, 8'h31, 1'b1, 2'b01, 1'b0);
        drive(1, 8'h55, 1'b1, 2'b11, 1'b1);
        #1;
        checks++; if (do_vld !== 2'b11 || dout !== 16'h4231) begin failures++; $display("FAIL par_do got=%b/%h exp=11/4231", do_vld, dout); end
        checks++; if (di_rdy !== 2'b00) begin failures++; $display("FAIL ill_rdy0 got=%b exp=00", di_rdy); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (di_rdy !== 2'b00 || do_vld !== 2'b00) begin failures++; $display("FAIL ill_hold c=%0d got=%b/%b exp=00/00", c, di_rdy, do_vld); end
        end
        drive(1, 8'h55, 1'b1, 2'b11, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_rdy = 2'b00;
        drive(1, 8'hD0, 1'b0, 2'b01, 1'b1);
        #1;
        checks++; if (di_rdy !== 2'b10) begin failures++; $display("FAIL rmp_rdy0 got=%b exp=10", di_rdy); end
        tick();
        drive(1, 8'hD1, 1'b0, 2'b01, 1'b1);
        #1;
        checks++; if (di_rdy !== 2'b10) begin failures++; $display("FAIL rmp_rdy1 got=%b exp=10", di_rdy); end
        tick();
        drive(1, 8'hD2, 1'b0, 2'b01, 1'b1);
        rst = 1'b1;
        #1;
        checks++; if (di_rdy !== 2'b00 || do_vld !== 2'b00) begin failures++; $display("FAIL rmp_in_rst got=%b/%b exp=00/00", di_rdy, do_vld); end
        tick();
        rst = 1'b0;
        do_rdy = 2'b11;
        drive(1, 8'hD2, 1'b0, 2'b01, 1'b0);
        drive(0, 8'h77, 1'b1, 2'b01, 1'b1);
        #1;
        checks++; if (do_vld !== 2'b00) begin failures++; $display("FAIL rmp_empty got=%b exp=00", do_vld); end
        checks++; if (di_rdy !== 2'b01) begin failures++; $display("FAIL rmp_unlocked got=%b exp=01", di_rdy); end
        tick();
        drive(0, 8'h77, 1'b1, 2'b01, 1'b0);
        #1;
        checks++; if (do_vld !== 2'b01 || dout[7:0] !== 8'h77 || do_eof[0] !== 1'b1) begin failures++; $display("FAIL rmp_new got=%b/%h/%b exp=01/77/1", do_vld, dout[7:0], do_eof[0]); end
        tick();
        checks++; if (do_vld !== 2'b00) begin failures++; $display("FAIL rmp_drain got=%b exp=00", do_vld); end
    endtask

    initial begin
        di = '0;
        di_eof = '0;
        di_dec = '0;
        di_vld = '0;
        test_reset();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_parallel_illegal();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/om_sync.md
# om_sync

Synchronous output module (OM) for the clocked variant of the SDM-Clos router. It sits at the far end of the Clos fabric from the input modules, receiving flits from the MN central-module (CM) links. Each flit is steered to one of NN output ports by its one-hot decoded direction. Each output locks onto one CM input for a whole packet (wormhole): round-robin arbitration at packet head, release on EOF. Each output port has a 2-entry FIFO that buffers it from downstream.

## Interface
Parameters:
- MN, 2, number of CM inputs
- NN, 2, number of output ports; also the width of the decoded direction
- DW, 8, flit data width

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- di  in  MN*DW  input flit data; input i occupies bits [i*DW +: DW]
- di_eof  in  MN  input flit is the last flit of its packet
- di_dec  in  MN*NN  decoded direction, one-hot; input i occupies bits [i*NN +: NN]
- di_vld  in  MN  input flit valid
- di_rdy  out  MN  input flit accepted this cycle when di_vld & di_rdy
- do  out  NN*DW  output flit data; output j occupies bits [j*DW +: DW]
- do_eof  out  NN  output flit is the last flit of its packet
- do_vld  out  NN  output flit valid
- do_rdy  in  NN  downstream ready

## Operation
- Request: input i requests output j when di_vld[i] & di_dec[i][j] and di_dec[i] is exactly one-hot.
- A non-one-hot di_dec (zero or multi-hot) with di_vld=1 requests nothing. di_rdy[i] stays 0 and the flit stalls indefinitely. This is not an error state.
- Per-output FSM with two states, IDLE and LOCKED(owner):
  - IDLE: a round-robin arbiter grants the first requester at or after ptr[j], scanning i = ptr, ptr+1, …, wrapping modulo MN.
  - Grant with FIFO not full: the flit is pushed this cycle and ptr[j] <= owner+1 mod MN. If eof=0 the FSM goes to LOCKED(owner); if eof=1 it stays IDLE (single-flit packet).
  - LOCKED(o): only input o may push, and only while it requests j. Pushing an eof=1 flit returns the FSM to IDLE. ptr does not move while LOCKED.
  - Other inputs requesting a LOCKED output are held with di_rdy=0.
- di_rdy[i] = 1 iff some output j grants, or is locked to, i; i requests j; and FIFO j holds fewer than 2 entries.
  - di_rdy never depends on do_rdy in the same cycle (no bypass path).
- FIFO: 2 entries per output, each DW+1 bits (data, eof).
  - Push when di_vld & di_rdy. Pop when do_vld & do_rdy.
  - Push and pop in the same cycle are allowed at count 1, leaving count at 1.
  - do/do_eof always show the head entry; do_vld = (count != 0).
- Different outputs operate fully independently. Several inputs may push to distinct outputs in the same cycle.
- Reset: all FSMs go to IDLE, all ptr to 0, FIFOs empty.
  - A packet in progress is abandoned. Recovery is the upstream's job.
  - After reset, flits arriving mid-packet are treated as packet heads.

## Timing
- Reset values: do_vld=0, di_rdy=0 while rst=1. do and do_eof = 0.
- Latency: a flit accepted at edge N appears with do_vld=1 after edge N, i.e. one cycle.
- Throughput: one flit per cycle per output while do_rdy=1 is held. Count stays at 1 in this steady state.
- Backpressure: with do_rdy=0, an output accepts at most 2 flits, then drops di_rdy.
  - di_rdy rises again the cycle after the first pop (count back to 1).
- Arbitration decision and first-flit transfer happen in the same cycle. No cycle is spent idle between back-to-back packets from different inputs.
- Inputs must hold di, di_eof, di_dec and di_vld stable until accepted.

## Test plan
- Reset: drive rst=1 for 2 cycles with di_vld=11. Require di_rdy=00, do_vld=00, do=0. On release, input 0 is granted first (ptr=0).
- Contention: both inputs send 3-flit packets to output 1, with data 0xA0–0xA2 and 0xB0–0xB2, do_rdy=11.
  - Require do[1] to show A0 A1 A2 B0 B1 B2 on consecutive cycles with no interleave.
  - Require di_rdy[1]=0 during A's packet.
- Round-robin: repeated single-flit (eof=1) packets from both inputs to output 0. Require the grant to alternate 0,1,0,1.
- Backpressure: hold do_rdy[0]=0 and stream 4 flits to output 0.
  - Require exactly 2 accepted, then di_rdy[0]=0.
  - Raise do_rdy: the head pops the same cycle, di_rdy returns next cycle, and order is preserved.
- Parallel and illegal: input 0 targets output 0 (dec=01) while input 1 targets output 1 (dec=10). Require both accepted in the same cycle.
  - Then drive input 1 with dec=11. Require di_rdy[1]=0 indefinitely and no output change.
- Reset mid-packet: send 2 of 4 flits from input 1 to output 0, then pulse rst.
  - Require FIFO 0 empty and output 0 unlocked.
  - A new packet from input 0 is accepted the cycle after reset release.
